multdiv_controller: RTL and testbench
=====================================

// Module: multdiv_controller
// PURPOSE
//   Sequences the shared multdiv unit for the processor execute stage.
//   Accepts one MULT/DIV request with a destination register tag, latches the operands and issues a one-cycle ctrl pulse.
//   Stalls the pipeline until data_resultRDY, then presents result/exception on a writeback handshake.
//   Supports a pipeline flush that discards an in-flight operation.
// PARAMETERS
//   TIMEOUT_CYCLES  64  max BUSY/DRAIN cycles before forced abort (used only with MULTDIV_TIMEOUT_EN)
// PORTS
//   clock         in   1   single clock, rising edge
//   reset         in   1   synchronous, active-high
//   req_valid     in   1   execute stage presents a mult/div request
//   req_op        in   1   0 = MULT, 1 = DIV
//   req_a         in   32  operand A
//   req_b         in   32  operand B
//   req_rd        in   5   destination register tag
//   req_ready     out  1   controller idle; request accepted when req_valid & req_ready & ~flush
//   stall         out  1   pipeline stall; high in every state except IDLE
//   flush         in   1   discard current/in-flight operation
//   md_operandA   out  32  to multdiv data_operandA; held stable from START until leaving BUSY/DRAIN
//   md_operandB   out  32  to multdiv data_operandB
//   md_ctrl_MULT  out  1   one-cycle start pulse to multdiv
//   md_ctrl_DIV   out  1   one-cycle start pulse to multdiv
//   md_result     in   32  multdiv data_result
//   md_exception  in   1   multdiv data_exception
//   md_resultRDY  in   1   multdiv data_resultRDY
//   wb_valid      out  1   writeback data valid (registered)
//   wb_ready      in   1   writeback port accepts
//   wb_rd         out  5   tag of completed op
//   wb_data       out  32  result
//   wb_exception  out  1   overflow / divide-by-zero / timeout
// BEHAVIOUR
//   - Reset: state=IDLE; all registered outputs 0; req_ready=1, stall=0 (decoded from state).
//   - Reset mid-operation: IDLE on the next edge; a late md_resultRDY is ignored in IDLE.
//   - FSM IDLE -> START: on accept, latch op/a/b/rd.
//   - FSM START: exactly one of md_ctrl_MULT/md_ctrl_DIV high for this cycle only; md_resultRDY ignored; -> BUSY.
//   - FSM BUSY: on md_resultRDY, capture md_result/md_exception -> DONE.
//   - FSM DONE: wb_valid=1 with data/rd/exception held stable until fire = wb_valid & wb_ready & ~flush; on fire -> IDLE.
//   - Timing: accept at edge 0, ctrl pulse in cycle 1, wb_valid the cycle after md_resultRDY is sampled.
//   - Back-to-back: IDLE-only accept gives a one-cycle bubble between ops.
//   - Flush in IDLE: the request is not accepted.
//   - Flush in START or BUSY: -> DRAIN; ctrl pulse (if START) still issued.
//   - FSM DRAIN: wait md_resultRDY, discard, -> IDLE; no wb_valid. The multdiv unit has no abort.
//   - Flush in DONE: wb_valid drops, -> IDLE, no transfer, even if wb_ready is high the same cycle.
//   - Flush coincident with md_resultRDY in BUSY: result discarded, -> IDLE.
//   - Only one operation is ever in flight; md_ctrl_* is never pulsed outside START.
// CONFIGURATION
//   MULTDIV_TIMEOUT_EN defined:
//     - A cycle counter clears on entering START and counts in BUSY/DRAIN.
//     - BUSY reaching TIMEOUT_CYCLES -> DONE with wb_data=0, wb_exception=1.
//     - DRAIN reaching TIMEOUT_CYCLES -> IDLE.
//   MULTDIV_TIMEOUT_EN undefined: no counter; BUSY/DRAIN wait indefinitely for md_resultRDY.
// STRUCTURE
//   multdiv_pkg contents:
//     - state encoding IDLE/START/BUSY/DRAIN/DONE (3 bits)
//     - OP_MULT=1'b0, OP_DIV=1'b1
//     - DATA_W=32, TAG_W=5
//   Sub-module multdiv_watchdog: timeout counter with clear/enable/expired; instantiated only under MULTDIV_TIMEOUT_EN.
//   No other sub-modules.
// TESTING (bench multdiv model with programmable latency)
//   1. mult a=7 b=6 rd=5, latency 16 -> single md_ctrl_MULT pulse in cycle 1; stall high throughout; wb_valid data=42 rd=5 exc=0.
//   2. div a=100 b=0 rd=9, model exception=1 -> single md_ctrl_DIV pulse; wb_exception=1, wb_rd=9.
//   3. mult, flush in BUSY cycle 4 -> no wb_valid; req_ready=1 the cycle after model RDY; then mult 3*3 -> wb_data=9.
//   4. div 100/7, wb_ready low 5 cycles in DONE -> wb_valid/wb_data=14 held stable, req_ready=0 until fire.
//   5. reset asserted mid-BUSY -> next cycle req_ready=1, stall=0, wb_valid=0; late model RDY produces no writeback.
//   6. MULTDIV_TIMEOUT_EN, TIMEOUT_CYCLES=8, model never RDY -> DONE after 8 BUSY cycles, wb_data=0, wb_exception=1.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multdiv controller slice.
package multdiv_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 5;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BUSY  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/multdiv_if.sv
// Request, multdiv-unit and writeback signals shared by the controller and its environment.
interface multdiv_if;
  import multdiv_pkg::*;

  logic              req_valid;
  logic              req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [TAG_W-1:0]  req_rd;
  logic              req_ready;
  logic              stall;
  logic              flush;

  logic [DATA_W-1:0] md_operandA;
  logic [DATA_W-1:0] md_operandB;
  logic              md_ctrl_MULT;
  logic              md_ctrl_DIV;
  logic [DATA_W-1:0] md_result;
  logic              md_exception;
  logic              md_resultRDY;

  logic              wb_valid;
  logic              wb_ready;
  logic [TAG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_exception;

  modport master (
    input  req_valid, req_op, req_a, req_b, req_rd, flush,
           md_result, md_exception, md_resultRDY, wb_ready,
    output req_ready, stall, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
           wb_valid, wb_rd, wb_data, wb_exception
  );

  modport slave (
    output req_valid, req_op, req_a, req_b, req_rd, flush,
           md_result, md_exception, md_resultRDY, wb_ready,
    input  req_ready, stall, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
           wb_valid, wb_rd, wb_data, wb_exception
  );

endinterface

// File: rtl/multdiv_watchdog.sv
// Saturating cycle counter that flags a stuck multdiv operation.
// Only instantiated when MULTDIV_TIMEOUT_EN is defined.
module multdiv_watchdog #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  // Saturates at the last value so a drain that follows a timeout still sees expiry.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/multdiv_controller.sv
// Sequences one MULT/DIV operation on the shared multdiv unit and hands the result to writeback.
// Optional forced abort of stuck operations: define MULTDIV_TIMEOUT_EN.
module multdiv_controller
  import multdiv_pkg::*;
`ifdef MULTDIV_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
)
`endif
(
  input  logic      clock,
  input  logic      reset,
  multdiv_if.master bus
);

  state_t            state;
  state_t            state_nx;
  logic              op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [TAG_W-1:0]  rd_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              wb_exc_q;
  logic              load_req;
  logic              load_result;
  logic              load_timeout;
  logic              timeout_hit;

`ifdef MULTDIV_TIMEOUT_EN
  logic wd_clear;
  logic wd_enable;

  assign wd_clear  = (state == START);
  assign wd_enable = (state == BUSY) || (state == DRAIN);

  multdiv_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= OP_MULT;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      wb_data_q <= '0;
      wb_exc_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (load_req) begin
        op_q <= bus.req_op;
        a_q  <= bus.req_a;
        b_q  <= bus.req_b;
        rd_q <= bus.req_rd;
      end
      if (load_result) begin
        wb_data_q <= bus.md_result;
        wb_exc_q  <= bus.md_exception;
      end else if (load_timeout) begin
        wb_data_q <= '0;
        wb_exc_q  <= 1'b1;
      end
    end
  end

  // The multdiv unit cannot be aborted, so a flush before the result arrives parks in DRAIN.
  always_comb begin
    state_nx     = state;
    load_req     = 1'b0;
    load_result  = 1'b0;
    load_timeout = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid && !bus.flush) begin
          state_nx = START;
          load_req = 1'b1;
        end
      end
      START: state_nx = bus.flush ? DRAIN : BUSY;
      BUSY: begin
        if (bus.flush) begin
          state_nx = bus.md_resultRDY ? IDLE : DRAIN;
        end else if (bus.md_resultRDY) begin
          state_nx    = DONE;
          load_result = 1'b1;
        end else if (timeout_hit) begin
          state_nx     = DONE;
          load_timeout = 1'b1;
        end
      end
      DRAIN: begin
        if (bus.md_resultRDY || timeout_hit) state_nx = IDLE;
      end
      DONE: begin
        if (bus.flush || bus.wb_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.req_ready    = (state == IDLE);
  assign bus.stall        = (state != IDLE);
  assign bus.md_operandA  = a_q;
  assign bus.md_operandB  = b_q;
  assign bus.md_ctrl_MULT = (state == START) && (op_q == OP_MULT);
  assign bus.md_ctrl_DIV  = (state == START) && (op_q == OP_DIV);
  assign bus.wb_valid     = (state == DONE);
  assign bus.wb_rd        = rd_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.wb_exception = wb_exc_q;

endmodule

// File: tb/tb_multdiv_controller.sv
// Self-checking bench for multdiv_controller with a latency-programmable multdiv model.
// Adds the forced-abort sequence when MULTDIV_TIMEOUT_EN is defined.
module tb_multdiv_controller;
  import multdiv_pkg::*;

`ifdef MULTDIV_TIMEOUT_EN
  localparam int LONG_LAT = 6;
`else
  localparam int LONG_LAT = 16;
`endif

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    int          latency;
    int          hold;
    logic [31:0] exp_data;
    logic        exp_exc;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   model_latency = 1;
  int   remaining = 0;
  logic [31:0] pend_result;
  logic        pend_exc;
  vec_t vecs[6];

  multdiv_if bus();

`ifdef MULTDIV_TIMEOUT_EN
  multdiv_controller #(.TIMEOUT_CYCLES(8)) dut (.clock(clock), .reset(reset), .bus(bus.master));
`else
  multdiv_controller dut (.clock(clock), .reset(reset), .bus(bus.master));
`endif

  always #5 clock = ~clock;

  // Multdiv unit model: result appears model_latency cycles after the start pulse; 0 means never.
  initial begin
    bus.md_resultRDY = 1'b0;
    bus.md_result    = '0;
    bus.md_exception = 1'b0;
    forever begin
      @(negedge clock);
      bus.md_resultRDY = 1'b0;
      if (remaining > 0) begin
        remaining--;
        if (remaining == 0) begin
          bus.md_resultRDY = 1'b1;
          bus.md_result    = pend_result;
          bus.md_exception = pend_exc;
        end
      end
      if (bus.md_ctrl_MULT || bus.md_ctrl_DIV) begin
        if (bus.md_ctrl_MULT) begin
          pend_result = bus.md_operandA * bus.md_operandB;
          pend_exc    = 1'b0;
        end else if (bus.md_operandB == 32'd0) begin
          pend_result = 32'd0;
          pend_exc    = 1'b1;
        end else begin
          pend_result = bus.md_operandA / bus.md_operandB;
          pend_exc    = 1'b0;
        end
        remaining = model_latency;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Presents a request in IDLE; returns at the negedge of the START cycle.
  task automatic startOp(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int lat);
    model_latency = lat;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_rd    = rd;
    @(negedge clock);
    bus.req_valid = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    int   c;
    logic bad_stall;
    logic bad_pulse;
    logic bad_hold;
    checkOutput("req_ready before op", 32'(bus.req_ready), 32'd1);
    startOp(v.op, v.a, v.b, v.rd, v.latency);
    checkOutput("ctrl_MULT in START", 32'(bus.md_ctrl_MULT), 32'(v.op == OP_MULT));
    checkOutput("ctrl_DIV in START", 32'(bus.md_ctrl_DIV), 32'(v.op == OP_DIV));
    checkOutput("md_operandA", bus.md_operandA, v.a);
    c = 0;
    bad_stall = 1'b0;
    bad_pulse = 1'b0;
    while (!bus.wb_valid && c < 200) begin
      if (!bus.stall) bad_stall = 1'b1;
      @(negedge clock);
      c++;
      if (bus.md_ctrl_MULT || bus.md_ctrl_DIV) bad_pulse = 1'b1;
    end
    checkOutput("wb_valid latency", 32'(c), 32'(v.latency + 1));
    checkOutput("stall during op", 32'(bad_stall || !bus.stall), 32'd0);
    checkOutput("single ctrl pulse", 32'(bad_pulse), 32'd0);
    checkOutput("wb_data", bus.wb_data, v.exp_data);
    checkOutput("wb_rd", 32'(bus.wb_rd), 32'(v.rd));
    checkOutput("wb_exception", 32'(bus.wb_exception), 32'(v.exp_exc));
    if (v.hold > 0) begin
      bad_hold = 1'b0;
      repeat (v.hold) begin
        @(negedge clock);
        if (!bus.wb_valid || bus.wb_data !== v.exp_data || bus.req_ready) bad_hold = 1'b1;
      end
      checkOutput("DONE held until fire", 32'(bad_hold), 32'd0);
    end
    bus.wb_ready = 1'b1;
    @(negedge clock);
    bus.wb_ready = 1'b0;
    checkOutput("wb_valid after fire", 32'(bus.wb_valid), 32'd0);
    checkOutput("req_ready after fire", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic bad;
    int   c;
    vecs[0] = '{OP_MULT, 32'd7,          32'd6,   5'd5,  LONG_LAT, 0, 32'd42,         1'b0};
    vecs[1] = '{OP_DIV,  32'd100,        32'd0,   5'd9,  4,        0, 32'd0,          1'b1};
    vecs[2] = '{OP_DIV,  32'd100,        32'd7,   5'd3,  8,        5, 32'd14,         1'b0};
    vecs[3] = '{OP_MULT, 32'd3,          32'd3,   5'd1,  1,        0, 32'd9,          1'b0};
    vecs[4] = '{OP_MULT, 32'hFFFF_FFFF,  32'd2,   5'd31, 2,        1, 32'hFFFF_FFFE,  1'b0};
    vecs[5] = '{OP_DIV,  32'd7,          32'd100, 5'd0,  3,        0, 32'd0,          1'b0};

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_rd    = '0;
    bus.flush     = 1'b0;
    bus.wb_ready  = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("reset req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("reset stall", 32'(bus.stall), 32'd0);
    checkOutput("reset wb_valid", 32'(bus.wb_valid), 32'd0);
    checkOutput("reset ctrl", 32'({bus.md_ctrl_MULT, bus.md_ctrl_DIV}), 32'd0);
    checkOutput("reset wb_data", bus.wb_data, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] table vectors");
    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    $display("[TB] flush in IDLE");
    bus.req_valid = 1'b1;
    bus.flush     = 1'b1;
    bus.req_a     = 32'd11;
    @(negedge clock);
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    checkOutput("flush IDLE req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("flush IDLE no pulse", 32'({bus.md_ctrl_MULT, bus.md_ctrl_DIV}), 32'd0);

    $display("[TB] flush in BUSY cycle 4");
    startOp(OP_MULT, 32'd5, 32'd5, 5'd2, 7);
    repeat (4) @(negedge clock);
    bus.flush = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    checkOutput("DRAIN stall", 32'(bus.stall), 32'd1);
    bad = 1'b0;
    repeat (2) begin
      @(negedge clock);
      if (bus.req_ready || bus.wb_valid) bad = 1'b1;
    end
    checkOutput("DRAIN waits for RDY", 32'(bad), 32'd0);
    @(negedge clock);
    checkOutput("DRAIN done req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("DRAIN no wb_valid", 32'(bus.wb_valid), 32'd0);
    applyStimulus(vecs[3]);

    $display("[TB] flush in START");
    startOp(OP_DIV, 32'd50, 32'd5, 5'd8, 3);
    checkOutput("START flush pulse", 32'(bus.md_ctrl_DIV), 32'd1);
    bus.flush = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    checkOutput("START flush stall", 32'(bus.stall), 32'd1);
    bad = 1'b0;
    repeat (2) begin
      @(negedge clock);
      if (bus.req_ready || bus.wb_valid || bus.md_ctrl_DIV) bad = 1'b1;
    end
    checkOutput("START flush drain", 32'(bad), 32'd0);
    @(negedge clock);
    checkOutput("START flush idle", 32'(bus.req_ready), 32'd1);

    $display("[TB] flush coincident with RDY");
    startOp(OP_MULT, 32'd6, 32'd6, 5'd4, 5);
    repeat (5) @(negedge clock);
    bus.flush = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    checkOutput("flush+RDY wb_valid", 32'(bus.wb_valid), 32'd0);
    checkOutput("flush+RDY req_ready", 32'(bus.req_ready), 32'd1);

    $display("[TB] flush in DONE with wb_ready");
    startOp(OP_MULT, 32'd2, 32'd8, 5'd4, 2);
    repeat (3) @(negedge clock);
    checkOutput("DONE wb_data", bus.wb_data, 32'd16);
    bus.flush    = 1'b1;
    bus.wb_ready = 1'b1;
    @(negedge clock);
    bus.flush    = 1'b0;
    bus.wb_ready = 1'b0;
    checkOutput("flush DONE wb_valid", 32'(bus.wb_valid), 32'd0);
    checkOutput("flush DONE req_ready", 32'(bus.req_ready), 32'd1);

    $display("[TB] reset mid-BUSY");
    startOp(OP_MULT, 32'd4, 32'd4, 5'd7, 6);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("mid reset req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("mid reset stall", 32'(bus.stall), 32'd0);
    checkOutput("mid reset wb_valid", 32'(bus.wb_valid), 32'd0);
    checkOutput("mid reset operandA", bus.md_operandA, 32'd0);
    bad = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (bus.wb_valid || !bus.req_ready) bad = 1'b1;
    end
    checkOutput("late RDY ignored", 32'(bad), 32'd0);
    applyStimulus(vecs[3]);

`ifdef MULTDIV_TIMEOUT_EN
    $display("[TB] timeout");
    startOp(OP_MULT, 32'd1, 32'd1, 5'd6, 0);
    c = 0;
    while (!bus.wb_valid && c < 200) begin
      @(negedge clock);
      c++;
    end
    checkOutput("timeout latency", 32'(c), 32'd9);
    checkOutput("timeout wb_data", bus.wb_data, 32'd0);
    checkOutput("timeout wb_exception", 32'(bus.wb_exception), 32'd1);
    checkOutput("timeout wb_rd", 32'(bus.wb_rd), 32'd6);
    bus.wb_ready = 1'b1;
    @(negedge clock);
    bus.wb_ready = 1'b0;
    checkOutput("timeout fire idle", 32'(bus.req_ready), 32'd1);
`else
    c = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
